// File: rtl/rs232_tx_arbiter.sv
// Round-robin arbiter sharing one RS232 byte transmitter among N_REQ requesters.
// A grant covers a whole message, capped at MAX_BURST bytes before forced rotation.
module rs232_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_vld,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_rdy,
  output logic [N_REQ-1:0]     grant,
  output logic [7:0]           uart_data,
  output logic                 uart_vld,
  input  logic                 uart_rdy,
  output logic                 busy,
  output logic [2:0]           dbg_state
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    SEND      = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  state_t          state_q;
  logic [N_REQ-1:0] grant_q;
  logic [PW-1:0]   gidx_q;
  logic [PW-1:0]   ptr_q;
  logic [7:0]      count_q;
  logic [7:0]      data_q;
  logic            last_q;
  logic            uart_vld_q;

  logic            win_found_d;
  logic [PW-1:0]   win_idx_d;

  // Index base+k wrapped modulo N_REQ.
  function automatic logic [PW-1:0] rot_idx(input logic [PW-1:0] base, input int k);
    logic [PW:0] sum;
    sum = {1'b0, base} + (PW+1)'(k);
    if (sum >= (PW+1)'(N_REQ)) sum = sum - (PW+1)'(N_REQ);
    return sum[PW-1:0];
  endfunction

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    return (i == PW'(N_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  // Scan from the highest offset down so the requester closest to ptr wins.
  always_comb begin
    win_found_d = 1'b0;
    win_idx_d   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_vld[rot_idx(ptr_q, k)]) begin
        win_found_d = 1'b1;
        win_idx_d   = rot_idx(ptr_q, k);
      end
    end
  end

  // Handshakes: a byte moves on a rising clock edge exactly when valid and ready are both
  // high; valid, once raised, stays high with stable data until that edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      ptr_q      <= '0;
      count_q    <= 8'd0;
      data_q     <= 8'h00;
      last_q     <= 1'b0;
      uart_vld_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found_d) begin
            grant_q <= N_REQ'(1) << win_idx_d;
            gidx_q  <= win_idx_d;
            count_q <= 8'd0;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (req_vld[gidx_q]) begin
            data_q     <= req_data[{gidx_q, 3'b000} +: 8];
            last_q     <= req_last[gidx_q];
            count_q    <= count_q + 8'd1;
            uart_vld_q <= 1'b1;
            state_q    <= SEND;
          end else begin
            grant_q <= '0;
            ptr_q   <= next_idx(gidx_q);
            state_q <= IDLE;
          end
        end
        SEND: begin
          if (uart_rdy) begin
            uart_vld_q <= 1'b0;
            state_q    <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (!uart_rdy) state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (uart_rdy) begin
            if (last_q || (count_q == 8'(MAX_BURST))) begin
              grant_q <= '0;
              ptr_q   <= next_idx(gidx_q);
              state_q <= IDLE;
            end else begin
              state_q <= LOAD;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_rdy   = (state_q == LOAD) ? (req_vld & grant_q) : '0;
  assign grant     = grant_q;
  assign uart_data = data_q;
  assign uart_vld  = uart_vld_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Bench for rs232_tx_arbiter: message-level round-robin reference model feeding a byte
// scoreboard, a randomly paced transmitter model, and directed corner cases.
module tb_rs232_tx_arbiter;

  localparam int N_REQ     = 4;
  localparam int MAX_BURST = 16;
  localparam int W         = N_REQ + 8;

  logic                 clock;
  logic                 reset;
  logic [N_REQ-1:0]     req_vld;
  logic [8*N_REQ-1:0]   req_data;
  logic [N_REQ-1:0]     req_last;
  logic [N_REQ-1:0]     req_rdy;
  logic [N_REQ-1:0]     grant;
  logic [7:0]           uart_data;
  logic                 uart_vld;
  logic                 uart_rdy;
  logic                 busy;
  logic [2:0]           dbg_state;

  int checks;
  int errors;
  logic [W-1:0] exp_q[$];      // {grant one-hot, byte} in transfer order
  logic [8:0]   rq[N_REQ][$];  // driver side, {last, data}
  logic [8:0]   mq[N_REQ][$];  // model side, {last, data}
  int           m_ptr;
  int           first_g;
  logic         tx_hold;

  rs232_tx_arbiter #(.N_REQ(N_REQ), .MAX_BURST(MAX_BURST)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_vld   (req_vld),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_rdy   (req_rdy),
    .grant     (grant),
    .uart_data (uart_data),
    .uart_vld  (uart_vld),
    .uart_rdy  (uart_rdy),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Transmitter: accepts when idle, stays ready 0..2 cycles, then busy 1..6 cycles.
  initial begin
    int   dly;
    int   bsy;
    logic pend;
    uart_rdy = 1'b1;
    pend = 1'b0;
    dly = 0;
    bsy = 0;
    forever begin
      @(negedge clock);
      if (reset) pend = 1'b0;
      if (tx_hold) uart_rdy = 1'b0;
      else if (pend) begin
        if (dly > 0) dly--;
        else if (bsy > 0) begin
          uart_rdy = 1'b0;
          bsy--;
        end else begin
          uart_rdy = 1'b1;
          pend = 1'b0;
        end
      end else uart_rdy = 1'b1;
      if (!reset && uart_vld && uart_rdy) begin
        pend = 1'b1;
        dly  = $urandom_range(0, 2);
        bsy  = $urandom_range(1, 6);
      end
    end
  end

  // Monitor: pops the scoreboard on every transmitter transfer, checks protocol rules.
  initial begin
    logic         pv;
    logic [7:0]   pd;
    logic [W-1:0] e;
    pv = 1'b0;
    pd = 8'h00;
    forever begin
      @(negedge clock);
      #1;
      if (reset) pv = 1'b0;
      else begin
        if (pv) begin
          check("vld_hold", uart_vld, 1);
          check("data_hold", uart_data, pd);
        end
        check("rdy_outside_grant", req_rdy & ~grant, 0);
        check("grant_onehot0", $onehot0(grant), 1);
        check("busy_vs_grant", busy, grant != 0);
        if (uart_vld) check("rdy_while_sending", req_rdy, 0);
        if (uart_vld && uart_rdy) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_byte actual=%0h required=none", {grant, uart_data});
          end else begin
            e = exp_q.pop_front();
            check("byte", {grant, uart_data}, e);
          end
        end
        pv = uart_vld && !uart_rdy;
        pd = uart_data;
      end
    end
  end

  task automatic add_byte(input int i, input logic [7:0] d, input logic last);
    rq[i].push_back({last, d});
    mq[i].push_back({last, d});
  endtask

  task automatic add_msg(input int i, input int len);
    for (int j = 0; j < len; j++) add_byte(i, 8'($urandom_range(0, 255)), j == len - 1);
  endtask

  // Reference: serve queued messages round-robin, whole message or MAX_BURST bytes per turn.
  task automatic model_schedule();
    int               g;
    int               n;
    logic             stop;
    logic [8:0]       b;
    logic [N_REQ-1:0] oh;
    first_g = -1;
    forever begin
      g = -1;
      for (int k = 0; k < N_REQ; k++) begin
        int idx;
        idx = (m_ptr + k) % N_REQ;
        if (g < 0 && mq[idx].size() > 0) g = idx;
      end
      if (g < 0) break;
      if (first_g < 0) first_g = g;
      oh = '0;
      oh[g] = 1'b1;
      n = 0;
      stop = 1'b0;
      while (!stop) begin
        b = mq[g].pop_front();
        n++;
        exp_q.push_back({oh, b[7:0]});
        stop = b[8] || (n == MAX_BURST) || (mq[g].size() == 0);
      end
      m_ptr = (g + 1) % N_REQ;
    end
  endtask

  task automatic present();
    logic [8:0] b;
    for (int i = 0; i < N_REQ; i++) begin
      if (rq[i].size() > 0) begin
        b = rq[i][0];
        req_vld[i] = 1'b1;
        req_data[8*i +: 8] = b[7:0];
        req_last[i] = b[8];
      end else begin
        req_vld[i] = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i] = 1'b0;
      end
    end
  endtask

  task automatic run_traffic(input string name, input int budget);
    int               cyc;
    logic [N_REQ-1:0] hs;
    logic             empty;
    @(posedge clock);
    #1;
    present();
    cyc = 0;
    forever begin
      @(negedge clock);
      hs = req_vld & req_rdy;
      @(posedge clock);
      #1;
      cyc++;
      if (cyc == 1 && first_g >= 0) check({name, "_arb_latency"}, grant, 32'd1 << first_g);
      for (int i = 0; i < N_REQ; i++)
        if (hs[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      present();
      empty = 1'b1;
      for (int i = 0; i < N_REQ; i++) if (rq[i].size() != 0) empty = 1'b0;
      if (empty && !busy) break;
      if (cyc >= budget) begin
        checks++;
        errors++;
        $display("FAIL %s_timeout actual=%0d cycles required=done", name, cyc);
        break;
      end
    end
    check({name, "_end_grant"}, grant, 0);
    check({name, "_end_busy"}, busy, 0);
    check({name, "_end_vld"}, uart_vld, 0);
    check({name, "_all_sent"}, exp_q.size(), 0);
    exp_q.delete();
    for (int i = 0; i < N_REQ; i++) rq[i].delete();
    present();
  endtask

  initial begin
    int cyc;
    checks = 0;
    errors = 0;
    m_ptr = 0;
    first_g = -1;
    tx_hold = 1'b0;
    reset = 1'b1;
    req_vld = '0;
    req_data = '0;
    req_last = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_grant", grant, 0);
    check("rst_req_rdy", req_rdy, 0);
    check("rst_uart_vld", uart_vld, 0);
    check("rst_busy", busy, 0);
    check("rst_uart_data", uart_data, 8'h00);
    @(negedge clock);
    reset = 1'b0;

    // Single one-byte message.
    add_byte(0, 8'h41, 1'b1);
    model_schedule();
    run_traffic("single", 500);

    // All four requesting one-byte messages, requester 0 twice.
    for (int i = 0; i < N_REQ; i++) add_msg(i, 1);
    add_msg(0, 1);
    model_schedule();
    run_traffic("rr_order", 2000);

    // 20-byte message split by MAX_BURST while requester 3 waits.
    add_msg(2, 20);
    add_msg(3, 1);
    model_schedule();
    run_traffic("burst_cap", 3000);

    // Requester 1 abandons its message while in LOAD.
    @(posedge clock);
    #1;
    req_vld = 4'b0010;
    req_data[15:8] = 8'h5a;
    req_last = 4'b0010;
    @(posedge clock);
    #1;
    check("abandon_grant", grant, 4'b0010);
    check("abandon_rdy_load", req_rdy, 4'b0010);
    req_vld = '0;
    req_last = '0;
    #1;
    check("abandon_rdy_drop", req_rdy, 0);
    @(posedge clock);
    #1;
    check("abandon_release", grant, 0);
    check("abandon_busy", busy, 0);
    check("abandon_no_vld", uart_vld, 0);
    m_ptr = 2;
    add_msg(0, 1);
    add_msg(2, 1);
    add_msg(3, 1);
    model_schedule();
    run_traffic("after_abandon", 2000);

    // Transmitter stalls 5000 cycles with a byte on offer.
    tx_hold = 1'b1;
    add_msg(2, 1);
    model_schedule();
    fork
      run_traffic("long_stall", 8000);
      begin
        repeat (5000) @(negedge clock);
        #2;
        check("stall_vld_held", uart_vld, 1);
        tx_hold = 1'b0;
      end
    join

    // Asynchronous reset while a byte is on offer.
    tx_hold = 1'b1;
    @(posedge clock);
    #1;
    req_vld = 4'b0010;
    req_data[15:8] = 8'hc3;
    req_last = 4'b0010;
    cyc = 0;
    while (!uart_vld && cyc < 20) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    check("rst_mid_in_send", uart_vld, 1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_grant", grant, 0);
    check("rst_mid_req_rdy", req_rdy, 0);
    check("rst_mid_vld", uart_vld, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_data", uart_data, 8'h00);
    req_vld = '0;
    req_last = '0;
    req_data = '0;
    @(negedge clock);
    reset = 1'b0;
    tx_hold = 1'b0;
    m_ptr = 0;
    add_msg(0, 1);
    add_msg(3, 1);
    model_schedule();
    run_traffic("after_reset", 2000);

    // Random message mixes.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N_REQ; i++) begin
        int nm;
        nm = $urandom_range(0, 2);
        for (int m = 0; m < nm; m++) add_msg(i, $urandom_range(1, 20));
      end
      model_schedule();
      if (first_g >= 0) run_traffic($sformatf("rand%0d", r), 20000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
